// File: rtl/dwc_ctrl_pkg.sv
// dwc_ctrl_pkg: shared state encoding and mismatch polarity for the DwC retry controller
package dwc_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2, FAULT = 2'd3} state_t;
    localparam logic DWC_MISMATCH = 1'b1;
endpackage

// File: rtl/dwc_sat_counter.sv
// dwc_sat_counter: saturating up-counter, sticks at all-ones instead of wrapping
module dwc_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dwc_retry_controller.sv
// dwc_retry_controller: sequences a duplicated-with-comparison unit, retrying on mismatch
// and latching a sticky fault once the mismatch outlives the retry budget
module dwc_retry_controller
    import dwc_ctrl_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             port_clk,
    input  logic             port_rst,
    input  logic             port_in_valid,
    output logic             port_in_ready,
    input  logic [WIDTH-1:0] port_in_0,
    input  logic [WIDTH-1:0] port_in_1,
    output logic [WIDTH-1:0] port_unit_a,
    output logic [WIDTH-1:0] port_unit_b,
    input  logic [WIDTH-1:0] port_unit_out,
    input  logic             port_unit_error,
    output logic             port_out_valid,
    input  logic             port_out_ready,
    output logic [WIDTH-1:0] port_out,
    output logic             port_out_retried,
    output logic             port_fault,
    input  logic             port_fault_clear,
    output logic [CNT_W-1:0] port_err_count
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    state_t r_state, w_next;
    logic [RW-1:0] r_retry;
    logic [WIDTH-1:0] r_unit_a, r_unit_b, r_out;
    logic r_retried, r_fault;
    logic w_exec, w_mis, w_last, w_inc;
    assign w_exec = r_state == EXEC;
    assign w_mis  = port_unit_error == DWC_MISMATCH;
    assign w_last = r_retry == RW'(MAX_RETRY);
    assign w_inc  = w_exec && w_mis;
    assign port_in_ready    = r_state == IDLE;
    assign port_out_valid   = r_state == OUT;
    assign port_unit_a      = r_unit_a;
    assign port_unit_b      = r_unit_b;
    assign port_out         = r_out;
    assign port_out_retried = r_retried;
    assign port_fault       = r_fault;

    always_ff @(posedge port_clk) r_state <= port_rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = port_in_valid ? EXEC : IDLE;
            EXEC:    w_next = !w_mis ? OUT : (w_last ? FAULT : EXEC);
            OUT:     w_next = port_out_ready ? IDLE : OUT;
            FAULT:   w_next = port_fault_clear ? IDLE : FAULT;
            default: w_next = IDLE;
        endcase
    end

    // The unit is combinational: whatever it shows during EXEC is the result of this attempt
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_unit_a  <= '0;
            r_unit_b  <= '0;
            r_out     <= '0;
            r_retried <= 1'b0;
            r_fault   <= 1'b0;
            r_retry   <= '0;
        end else begin
            if (r_state == IDLE && port_in_valid) begin
                r_unit_a <= port_in_0;
                r_unit_b <= port_in_1;
                r_retry  <= '0;
            end
            if (w_exec && !w_mis) begin
                r_out     <= port_unit_out;
                r_retried <= r_retry != '0;
            end
            if (w_inc && !w_last) r_retry <= r_retry + 1'b1;
            if (w_inc && w_last) r_fault <= 1'b1;
            if (r_state == FAULT && port_fault_clear) begin
                r_fault <= 1'b0;
                r_retry <= '0;
            end
        end
    end

    dwc_sat_counter #(.W(CNT_W)) u_cnt (
        .clk(port_clk),
        .clr(port_rst),
        .inc(w_inc),
        .cnt(port_err_count)
    );
endmodule
